alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control sequencer that sits between instruction memory, the register file and the 8-bit ALU, acting as the initiator side of the 3-bit ALU control interface. It fetches one instruction byte per instruction through a request/acknowledge handshake and decodes its 4-bit opcode. It then steps through EXEC/MEM/WB states, driving the ALU control code, operand select, register/memory strobes and PC updates, and consumes the ALU's `zero` and `slt` flags for branches and set-less-than.

## Interface
- `CNT_W`, 16: width of retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 8: instruction byte; `[7:4]` opcode, `[3:2]` rs, `[1:0]` rt/imm. Valid when `imem_ack`=1.
- `imem_req` out 1: fetch request, held until acknowledged.
- `imem_ack` in 1: fetch acknowledge; 1 cycle, only honoured while `imem_req`=1.
- `alu_zero` in 1: ALU zero/branch flag, combinational from `alu_ctrl`.
- `alu_slt` in 1: ALU set-less-than flag.
- `alu_ctrl` out 3: 000 idle, 001 add, 010 nand, 011 compare, 100 shl, 101 shr, 110 equal, 111 address.
- `alu_src_imm` out 1: 1 selects zero-extended `instr[1:0]` as ALU data2.
- `reg_we` out 1: register-file write pulse.
- `slt_we` out 1: slt register write pulse.
- `dmem_req` out 1: data-memory request, held until acknowledged.
- `dmem_we` out 1: 1 = store, valid with `dmem_req`.
- `dmem_ack` in 1: data-memory acknowledge.
- `pc_inc` out 1: PC+1 pulse.
- `pc_load` out 1: PC load-target pulse (branch/jump).
- `illegal` out 1: 1-cycle pulse on an undefined opcode.
- `halted` out 1: level, set by HALT.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset → FETCH.
- FETCH: `imem_req`=1. On `imem_ack`: latch `instr`, pulse `pc_inc`, go to DECODE.
- DECODE: drive `alu_ctrl`/`alu_src_imm` from the latched opcode.
  - 0 add→001
  - 1 nand→010
  - 2 shl→100
  - 3 shr→101
  - 4 addi→001 with imm
  - 5 slt→011
  - 6 beq→110
  - 7 blt→011
  - 8 lw→111 with imm
  - 9 sw→111 with imm
  - A jmp→000
  - F halt→000
  - Others: pulse `illegal` and treat as a no-op that retires.
- EXEC: `alu_ctrl` held stable; flags sampled at the end of the cycle.
  - 0–4: go to WB.
  - 5: pulse `slt_we` if `alu_slt`=1; retire; go to FETCH.
  - 6/7: pulse `pc_load` if `alu_zero`=1; retire; go to FETCH.
  - A: pulse `pc_load`; retire; go to FETCH.
  - 8/9: go to MEM.
  - F: retire; go to HALT.
- MEM: `dmem_req`=1 and `dmem_we`=(op==9), held until `dmem_ack`.
  - lw: go to WB.
  - sw: retire; go to FETCH.
- WB: pulse `reg_we`; retire; go to FETCH.
- HALT: all strobes 0 and `halted`=1 until `reset`.
- `alu_ctrl` returns to 000 in FETCH and HALT.
- `retired` increments by exactly 1 per completed instruction and wraps modulo 2^CNT_W.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational path from `imem_ack`/`dmem_ack` to outputs.
- Reset values:
  - State = FETCH.
  - `imem_req`=1 starting the cycle after reset deasserts.
  - `alu_ctrl`=000.
  - All other outputs 0.
  - `retired`=0.
- Latency with same-cycle ack:
  - R-type/addi: 4 cycles (F, D, E, W).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - slt/branch/jmp: 3 cycles.
- Each wait cycle on `imem_ack`/`dmem_ack` adds 1 cycle. Request and `dmem_we` stay stable while waiting.
- Acks arriving without a pending request are ignored.
- `reset` mid-instruction:
  - Aborts next cycle; no strobe for the aborted instruction.
  - `retired` clears.
  - Requests drop for the reset cycle.
- `illegal` and `pc_inc` never coincide with `pc_load`.

## Structure
- Shared package `aardvark_pkg`:
  - Opcode constants.
  - ALU control codes 000–111.
  - State enum.
- One sub-module, `opcode_decoder`: combinational opcode → {`alu_ctrl`, `alu_src_imm`, class (R, SLT, BR, JMP, MEM_LD, MEM_ST, HALT, ILL)}.
- The FSM, strobes and counter live in `alu_sequencer`.

## Test plan
- Reset, then `instr`=0x06 (add r1,r2) with immediate ack → `imem_req` 1 cycle; `pc_inc` at the ack; `alu_ctrl`=001 in D/E; `reg_we` in cycle 4; `retired`=1.
- `instr`=0x86 (lw) with `dmem_ack` delayed 3 cycles → `alu_ctrl`=111 and `alu_src_imm`=1; `dmem_req`=1 with `dmem_we`=0 for 4 cycles; `reg_we` once; 8 cycles total.
- `instr`=0x61 (beq) with `alu_zero`=1, then `alu_zero`=0 → `pc_load` once in EXEC for the first, none for the second; 3 cycles each.
- `instr`=0xB0 (illegal) → `illegal` pulses once; no `reg_we`/`dmem_req`; `retired` increments.
- Assert `reset` during MEM of a sw → `dmem_req` drops; `dmem_we` never completes; state is FETCH; `retired`=0.
- `instr`=0xF0 → `halted`=1; `imem_req` stays 0 for 20 cycles despite `imem_ack` pulses.

Source files
------------

// File: rtl/aardvark_pkg.sv
// Shared definitions for the aardvark multi-cycle core: opcodes, ALU control
// codes, sequencer states and instruction classes.
package aardvark_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_NAND = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_BLT  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ALU_IDLE = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_NAND = 3'b010,
        ALU_CMP  = 3'b011,
        ALU_SHL  = 3'b100,
        ALU_SHR  = 3'b101,
        ALU_EQ   = 3'b110,
        ALU_ADDR = 3'b111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_SLT,
        CLS_BR,
        CLS_JMP,
        CLS_MEM_LD,
        CLS_MEM_ST,
        CLS_HALT,
        CLS_ILL
    } instr_class_e;

    typedef struct packed {
        alu_ctrl_e    aluCtrl;
        logic         srcImm;
        instr_class_e cls;
    } decode_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the fetch, ALU-control, memory and status signals between the
// sequencer (master) and the surrounding datapath/memories (slave).
interface alu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       instr;
    logic             imem_req;
    logic             imem_ack;
    logic             alu_zero;
    logic             alu_slt;
    logic [2:0]       alu_ctrl;
    logic             alu_src_imm;
    logic             reg_we;
    logic             slt_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             pc_inc;
    logic             pc_load;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, imem_ack, alu_zero, alu_slt, dmem_ack,
        output imem_req, alu_ctrl, alu_src_imm, reg_we, slt_we, dmem_req,
               dmem_we, pc_inc, pc_load, illegal, halted, retired
    );

    modport slave (
        output instr, imem_ack, alu_zero, alu_slt, dmem_ack,
        input  imem_req, alu_ctrl, alu_src_imm, reg_we, slt_we, dmem_req,
               dmem_we, pc_inc, pc_load, illegal, halted, retired
    );
endinterface

// File: rtl/alu_sequencer_opcode_decoder.sv
// Pure combinational opcode decode: ALU control code, immediate select and
// the instruction class that steers the sequencer through its states.
module opcode_decoder
    import aardvark_pkg::*;
(
    input  logic [3:0] opcode_i,
    output decode_t    decode_o
);

    always_comb begin
        decode_o = '{aluCtrl: ALU_IDLE, srcImm: 1'b0, cls: CLS_ILL};
        case (opcode_i)
            OP_ADD:  decode_o = '{aluCtrl: ALU_ADD,  srcImm: 1'b0, cls: CLS_R};
            OP_NAND: decode_o = '{aluCtrl: ALU_NAND, srcImm: 1'b0, cls: CLS_R};
            OP_SHL:  decode_o = '{aluCtrl: ALU_SHL,  srcImm: 1'b0, cls: CLS_R};
            OP_SHR:  decode_o = '{aluCtrl: ALU_SHR,  srcImm: 1'b0, cls: CLS_R};
            OP_ADDI: decode_o = '{aluCtrl: ALU_ADD,  srcImm: 1'b1, cls: CLS_R};
            OP_SLT:  decode_o = '{aluCtrl: ALU_CMP,  srcImm: 1'b0, cls: CLS_SLT};
            OP_BEQ:  decode_o = '{aluCtrl: ALU_EQ,   srcImm: 1'b0, cls: CLS_BR};
            OP_BLT:  decode_o = '{aluCtrl: ALU_CMP,  srcImm: 1'b0, cls: CLS_BR};
            OP_LW:   decode_o = '{aluCtrl: ALU_ADDR, srcImm: 1'b1, cls: CLS_MEM_LD};
            OP_SW:   decode_o = '{aluCtrl: ALU_ADDR, srcImm: 1'b1, cls: CLS_MEM_ST};
            OP_JMP:  decode_o = '{aluCtrl: ALU_IDLE, srcImm: 1'b0, cls: CLS_JMP};
            OP_HALT: decode_o = '{aluCtrl: ALU_IDLE, srcImm: 1'b0, cls: CLS_HALT};
            default: decode_o = '{aluCtrl: ALU_IDLE, srcImm: 1'b0, cls: CLS_ILL};
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the 8-bit ALU,
// register file strobes, data memory handshake and PC control.
module alu_sequencer
    import aardvark_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.master bus
);

    seq_state_e       state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic             imemReq_q, imemReq_d;
    logic             pcInc_q, pcInc_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    decode_t   dec;
    alu_ctrl_e aluCtrl;
    logic      srcImm;
    logic      regWe, sltWe, dmemReq, dmemWe, pcLoad, illegal, halted, retire;

    // Register fields are consumed by the datapath, not by the sequencer.
    logic unusedOperandBits;
    assign unusedOperandBits = ^bus.instr[3:0];

    opcode_decoder uDecoder (
        .opcode_i (opcode_q),
        .decode_o (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            imemReq_q <= 1'b0;
            pcInc_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            imemReq_q <= imemReq_d;
            pcInc_q   <= pcInc_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        pcInc_d  = 1'b0;
        retire   = 1'b0;
        aluCtrl  = ALU_IDLE;
        srcImm   = 1'b0;
        regWe    = 1'b0;
        sltWe    = 1'b0;
        dmemReq  = 1'b0;
        dmemWe   = 1'b0;
        pcLoad   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (imemReq_q && bus.imem_ack) begin
                    opcode_d = bus.instr[7:4];
                    pcInc_d  = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                aluCtrl = dec.aluCtrl;
                srcImm  = dec.srcImm;
                if (dec.cls == CLS_ILL) begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                aluCtrl = dec.aluCtrl;
                srcImm  = dec.srcImm;
                case (dec.cls)
                    CLS_R:      state_d = ST_WB;
                    CLS_SLT: begin
                        sltWe   = bus.alu_slt;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_BR: begin
                        pcLoad  = bus.alu_zero;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_JMP: begin
                        pcLoad  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_MEM_LD, CLS_MEM_ST: state_d = ST_MEM;
                    CLS_HALT: begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end
                    default:    state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                aluCtrl = dec.aluCtrl;
                srcImm  = dec.srcImm;
                dmemReq = 1'b1;
                dmemWe  = (dec.cls == CLS_MEM_ST);
                if (bus.dmem_ack) begin
                    if (dec.cls == CLS_MEM_ST) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                aluCtrl = dec.aluCtrl;
                srcImm  = dec.srcImm;
                regWe   = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        // Fetch request is registered so acks never reach outputs combinationally.
        imemReq_d = (state_d == ST_FETCH);
        retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    end

    assign bus.imem_req    = imemReq_q;
    assign bus.pc_inc      = pcInc_q;
    assign bus.retired     = retired_q;
    assign bus.alu_ctrl    = aluCtrl;
    assign bus.alu_src_imm = srcImm;
    assign bus.reg_we      = regWe;
    assign bus.slt_we      = sltWe;
    assign bus.dmem_req    = dmemReq;
    assign bus.dmem_we     = dmemWe;
    assign bus.pc_load     = pcLoad;
    assign bus.illegal     = illegal;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus randomized instructions,
// each scored per instruction against cycle/strobe counts derived from the ISA rules.
module tb_alu_sequencer;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nPass = 0;
    int   nFail = 0;
    int   modelRetired = 0;

    alu_sequencer_if #(.CNT_W(CNT_W)) bus ();

    alu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ALU control code each opcode must present while it executes.
    function automatic logic [2:0] specCtrl(input logic [3:0] op);
        case (op)
            4'h0, 4'h4: return 3'b001;
            4'h1:       return 3'b010;
            4'h2:       return 3'b100;
            4'h3:       return 3'b101;
            4'h5, 4'h7: return 3'b011;
            4'h6:       return 3'b110;
            4'h8, 4'h9: return 3'b111;
            default:    return 3'b000;
        endcase
    endfunction

    // Runs one instruction from an open fetch to the next open fetch (or halt)
    // and scores the per-instruction totals against the ISA-level expectations.
    task automatic applyStimulus(input logic [7:0] code, input logic zeroIn, input logic sltIn,
                                 input int imemDelay, input int dmemDelay);
        logic [3:0] op;
        bit   isR, isSlt, isBr, isLd, isSt, isJmp, isHalt, isIll, fetched, done;
        int   expCyc, cycles, reqCyc, incCnt, loadCnt, regWeCnt, sltWeCnt, illCnt;
        int   dReqCnt, dWeCnt, clash, waitI, waitD, guard;
        logic [2:0] ctrlFetch, ctrlDec, ctrlExec;
        logic immDec;

        op     = code[7:4];
        isR    = (op <= 4'd4);
        isSlt  = (op == 4'd5);
        isBr   = (op == 4'd6) || (op == 4'd7);
        isLd   = (op == 4'd8);
        isSt   = (op == 4'd9);
        isJmp  = (op == 4'hA);
        isHalt = (op == 4'hF);
        isIll  = (op >= 4'hB) && (op <= 4'hE);
        fetched = 1'b0; done = 1'b0;
        cycles = 0; reqCyc = 0; incCnt = 0; loadCnt = 0; regWeCnt = 0; sltWeCnt = 0;
        illCnt = 0; dReqCnt = 0; dWeCnt = 0; clash = 0; waitI = 0; waitD = 0; guard = 0;
        ctrlFetch = 3'bxxx; ctrlDec = 3'bxxx; ctrlExec = 3'bxxx; immDec = 1'bx;

        while (!bus.imem_req && guard < 10) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            bus.instr    = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        checkOutput("fetchOpen", 32'(bus.imem_req), 32'd1);

        bus.alu_zero = zeroIn;
        bus.alu_slt  = sltIn;
        while (!done && cycles < 40) begin
            if (!fetched && bus.imem_req) begin
                bus.imem_ack = (waitI == imemDelay);
                waitI++;
            end else begin
                bus.imem_ack = 1'($urandom_range(0, 1));
            end
            bus.instr = bus.imem_ack ? code : 8'($urandom);
            if (bus.dmem_req) begin
                bus.dmem_ack = (waitD == dmemDelay);
                waitD++;
            end else begin
                bus.dmem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (cycles == 0) ctrlFetch = bus.alu_ctrl;
            if (cycles == imemDelay + 1) begin
                ctrlDec = bus.alu_ctrl;
                immDec  = bus.alu_src_imm;
            end
            if (cycles == imemDelay + 2) ctrlExec = bus.alu_ctrl;
            reqCyc   += int'(bus.imem_req);
            incCnt   += int'(bus.pc_inc);
            loadCnt  += int'(bus.pc_load);
            regWeCnt += int'(bus.reg_we);
            sltWeCnt += int'(bus.slt_we);
            illCnt   += int'(bus.illegal);
            dReqCnt  += int'(bus.dmem_req);
            dWeCnt   += int'(bus.dmem_req && bus.dmem_we);
            clash    += int'(bus.pc_load && (bus.pc_inc || bus.illegal));
            if (!fetched && bus.imem_req && bus.imem_ack) fetched = 1'b1;
            cycles++;
            @(negedge clk);
            done = fetched && (bus.imem_req || bus.halted);
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        checkOutput("instrCompletes", 32'(done), 32'd1);

        if (isR)        expCyc = 4;
        else if (isLd)  expCyc = 5 + dmemDelay;
        else if (isSt)  expCyc = 4 + dmemDelay;
        else if (isIll) expCyc = 2;
        else            expCyc = 3;
        expCyc += imemDelay;

        checkOutput($sformatf("cycles op%0h", op), 32'(cycles), 32'(expCyc));
        checkOutput("imemReqCycles", 32'(reqCyc), 32'(imemDelay + 1));
        checkOutput("pcIncCount", 32'(incCnt), 32'd1);
        checkOutput("pcLoadCount", 32'(loadCnt), 32'(isJmp || (isBr && zeroIn)));
        checkOutput("regWeCount", 32'(regWeCnt), 32'(isR || isLd));
        checkOutput("sltWeCount", 32'(sltWeCnt), 32'(isSlt && sltIn));
        checkOutput("illegalCount", 32'(illCnt), 32'(isIll));
        checkOutput("dmemReqCycles", 32'(dReqCnt), 32'((isLd || isSt) ? dmemDelay + 1 : 0));
        checkOutput("dmemWeCycles", 32'(dWeCnt), 32'(isSt ? dmemDelay + 1 : 0));
        checkOutput("pcLoadClash", 32'(clash), 32'd0);
        checkOutput("ctrlInFetch", 32'(ctrlFetch), 32'd0);
        checkOutput($sformatf("ctrlDecode op%0h", op), 32'(ctrlDec), 32'(specCtrl(op)));
        checkOutput("srcImmDecode", 32'(immDec), 32'((op == 4'h4) || isLd || isSt));
        if (!isIll) checkOutput("ctrlExec", 32'(ctrlExec), 32'(specCtrl(op)));
        modelRetired = (modelRetired + 1) % (1 << CNT_W);
        checkOutput("retired", 32'(bus.retired), 32'(modelRetired));
        checkOutput("haltedLevel", 32'(bus.halted), 32'(isHalt));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        reset        = 1'b1;
        bus.instr    = 8'h00;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.alu_zero = 1'b0;
        bus.alu_slt  = 1'b0;
        repeat (2) @(negedge clk);

        reset = 1'b0;
        #1;
        checkOutput("resetImemReq", 32'(bus.imem_req), 32'd0);
        checkOutput("resetCtrl", 32'(bus.alu_ctrl), 32'd0);
        checkOutput("resetRetired", 32'(bus.retired), 32'd0);
        checkOutput("resetStrobes", 32'({bus.reg_we, bus.slt_we, bus.dmem_req, bus.dmem_we,
                                         bus.pc_inc, bus.pc_load, bus.illegal, bus.halted,
                                         bus.alu_src_imm}), 32'd0);
        @(negedge clk);
        checkOutput("reqAfterReset", 32'(bus.imem_req), 32'd1);

        applyStimulus(8'h06, 1'b0, 1'b0, 0, 0);
        applyStimulus(8'h86, 1'b0, 1'b0, 0, 3);
        applyStimulus(8'h61, 1'b1, 1'b0, 0, 0);
        applyStimulus(8'h61, 1'b0, 1'b0, 0, 0);
        applyStimulus(8'hB0, 1'b0, 1'b0, 0, 0);
        applyStimulus(8'h51, 1'b0, 1'b1, 2, 0);
        applyStimulus(8'h93, 1'b0, 1'b0, 1, 2);

        for (int i = 0; i < 60; i++) begin
            applyStimulus({4'($urandom_range(0, 14)), 4'($urandom)},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Store aborted by reset while waiting in MEM.
        bus.instr    = 8'h95;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        guard = 0;
        while (!bus.dmem_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("swReachedMem", 32'(bus.dmem_req), 32'd1);
        checkOutput("swStoreFlag", 32'(bus.dmem_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abortStrobes", 32'({bus.dmem_req, bus.dmem_we, bus.imem_req, bus.reg_we,
                                         bus.pc_load, bus.illegal, bus.halted}), 32'd0);
        checkOutput("abortRetired", 32'(bus.retired), 32'd0);
        checkOutput("abortCtrl", 32'(bus.alu_ctrl), 32'd0);
        modelRetired = 0;
        @(negedge clk);
        checkOutput("abortRefetch", 32'(bus.imem_req), 32'd1);
        applyStimulus(8'h0D, 1'b0, 1'b0, 0, 0);

        applyStimulus(8'hF0, 1'b0, 1'b0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            bus.dmem_ack = 1'($urandom_range(0, 1));
            bus.instr    = 8'($urandom);
            #1;
            checkOutput("haltQuiet", 32'({bus.imem_req, bus.halted, bus.alu_ctrl, bus.reg_we,
                                          bus.slt_we, bus.dmem_req, bus.pc_inc, bus.pc_load,
                                          bus.illegal}), 32'(11'b010_0000_0000));
            @(negedge clk);
        end
        checkOutput("haltRetired", 32'(bus.retired), 32'(modelRetired));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
